// File: rtl/demux_1to2.sv
// 1-to-2 demultiplexer: combinational routing plus registered copy of the outputs.
// Optional per-lane activity counters and sticky saturation flag under DEMUX1TO2_STATS_EN.
module demux_1to2 #(
  parameter int CNT_W = 16
) (
  input  logic             in,
  input  logic             sel,
  output logic [1:0]       out,
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [1:0]       out_q,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             sat
);

  // Pure combinational path; no dependency on clk/rst/clr.
  assign out = {in & ~sel, in & sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 2'b00;
    end else begin
      out_q <= out;
    end
  end

`ifdef DEMUX1TO2_STATS_EN
  // hit[0] drives cnt0 (out[1] deliveries), hit[1] drives cnt1 (out[0] deliveries).
  logic [1:0] hit;
  logic [1:0] full_next;
  logic       sat_reg;
  logic       sat_next;

  assign hit = {out[0], out[1]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      assign full_next[gi] = &cnt_next;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (clr) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  assign sat_next = sat_reg | (|full_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_reg <= 1'b0;
    end else if (clr) begin
      sat_reg <= 1'b0;
    end else begin
      sat_reg <= sat_next;
    end
  end

  assign cnt0 = gen_cnt[0].cnt_reg;
  assign cnt1 = gen_cnt[1].cnt_reg;
  assign sat  = sat_reg;
`else
  logic unused_clr;
  assign unused_clr = clr;

  assign cnt0 = '0;
  assign cnt1 = '0;
  assign sat  = 1'b0;
`endif

endmodule

// File: tb/tb_demux_1to2.sv
// Directed self-checking bench for demux_1to2; counter checks adapt to DEMUX1TO2_STATS_EN.
module tb_demux_1to2;

`ifdef DEMUX1TO2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        in, sel, clk, rst, clr;
  logic        clk_en;
  logic [1:0]  out, out_q, out_s, out_q_s;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt0_s, cnt1_s;
  logic        sat, sat_s;

  int n_cmp = 0;
  int n_err = 0;

  demux_1to2 dut (
    .in(in), .sel(sel), .out(out), .clk(clk), .rst(rst), .clr(clr),
    .out_q(out_q), .cnt0(cnt0), .cnt1(cnt1), .sat(sat)
  );

  demux_1to2 #(.CNT_W(2)) dut_s (
    .in(in), .sel(sel), .out(out_s), .clk(clk), .rst(rst), .clr(clr),
    .out_q(out_q_s), .cnt0(cnt0_s), .cnt1(cnt1_s), .sat(sat_s)
  );

  initial begin
    clk    = 1'bx;
    clk_en = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    in  = 1'b0;
    sel = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_tab [4];
    exp_tab[0] = 2'b00; exp_tab[1] = 2'b10; exp_tab[2] = 2'b00; exp_tab[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      in  = i[0];
      sel = i[1];
      #10;
      n_cmp++;
      if (out !== exp_tab[i]) begin
        n_err++;
        $display("FAIL truth_table in=%0b sel=%0b: out=%b required %b", in, sel, out, exp_tab[i]);
      end
      $display("truth_table in=%0b sel=%0b out=%b", in, sel, out);
    end
  endtask

  task automatic test_reset();
    clk    = 1'b0;
    clk_en = 1'b1;
    clr    = 1'b0;
    in     = 1'b1;
    sel    = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_q !== 2'b00 || cnt0 !== 16'd0 || cnt1 !== 16'd0 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: out_q=%b cnt0=%0d cnt1=%0d sat=%b required 00/0/0/0", out_q, cnt0, cnt1, sat);
    end
    step();
    n_cmp++;
    if (out_q !== 2'b00 || out !== 2'b01) begin
      n_err++;
      $display("FAIL reset_hold: out_q=%b out=%b required out_q=00 out=01", out_q, out);
    end
    $display("reset out_q=%b out=%b", out_q, out);
  endtask

  task automatic test_registered();
    rst = 1'b0;
    in  = 1'b1;
    sel = 1'b1;
    step();
    n_cmp++;
    if (out_q !== 2'b01) begin
      n_err++;
      $display("FAIL registered_01: out_q=%b required 01", out_q);
    end
    sel = 1'b0;
    step();
    n_cmp++;
    if (out_q !== 2'b10) begin
      n_err++;
      $display("FAIL registered_10: out_q=%b required 10", out_q);
    end
    in = 1'b0;
    step();
    n_cmp++;
    if (out_q !== 2'b00) begin
      n_err++;
      $display("FAIL registered_00: out_q=%b required 00", out_q);
    end
    $display("registered out_q=%b", out_q);
  endtask

  task automatic test_counting();
    do_reset();
    in  = 1'b1;
    sel = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_cmp++;
      if (cnt0 !== (STATS ? 16'(i) : 16'd0)) begin
        n_err++;
        $display("FAIL count0_step%0d: cnt0=%0d required %0d", i, cnt0, STATS ? i : 0);
      end
    end
    sel = 1'b1;
    repeat (3) step();
    in = 1'b0;
    repeat (4) step();
    n_cmp++;
    if (cnt0 !== (STATS ? 16'd5 : 16'd0) || cnt1 !== (STATS ? 16'd3 : 16'd0) || sat !== 1'b0) begin
      n_err++;
      $display("FAIL counting: cnt0=%0d cnt1=%0d sat=%b required %0d/%0d/0",
               cnt0, cnt1, sat, STATS ? 5 : 0, STATS ? 3 : 0);
    end
    $display("counting cnt0=%0d cnt1=%0d sat=%b", cnt0, cnt1, sat);
  endtask

  task automatic test_clr();
    // Counters on dut are nonzero here in the stats build; clr wins over the increment.
    in  = 1'b1;
    sel = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || sat !== 1'b0 || out_q !== 2'b10) begin
      n_err++;
      $display("FAIL clr_priority: cnt0=%0d cnt1=%0d sat=%b out_q=%b required 0/0/0/10", cnt0, cnt1, sat, out_q);
    end
    $display("clr cnt0=%0d cnt1=%0d sat=%b out_q=%b", cnt0, cnt1, sat, out_q);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    logic       exp_sat;
    in  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    in  = 1'b1;
    sel = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_c   = STATS ? ((i >= 3) ? 2'd3 : 2'(i)) : 2'd0;
      exp_sat = STATS && (i >= 3);
      n_cmp++;
      if (cnt1_s !== exp_c || sat_s !== exp_sat || cnt0_s !== 2'd0) begin
        n_err++;
        $display("FAIL saturation_step%0d: cnt1=%0d sat=%b cnt0=%0d required %0d/%b/0",
                 i, cnt1_s, sat_s, cnt0_s, exp_c, exp_sat);
      end
      $display("saturation step%0d cnt1=%0d sat=%b", i, cnt1_s, sat_s);
    end
    // clr on the same edge as a qualifying cycle at saturation
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++;
    if (cnt1_s !== 2'd0 || sat_s !== 1'b0 || out_q_s !== 2'b01) begin
      n_err++;
      $display("FAIL clr_at_sat: cnt1=%0d sat=%b out_q=%b required 0/0/01", cnt1_s, sat_s, out_q_s);
    end
    $display("clr_at_sat cnt1=%0d sat=%b", cnt1_s, sat_s);
  endtask

  task automatic test_async_reset();
    do_reset();
    in  = 1'b1;
    sel = 1'b0;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_q !== 2'b00 || cnt0 !== 16'd0 || cnt0_s !== 2'd0 || sat_s !== 1'b0 || out !== 2'b10) begin
      n_err++;
      $display("FAIL async_reset: out_q=%b cnt0=%0d cnt0_s=%0d sat_s=%b out=%b required 00/0/0/0/10",
               out_q, cnt0, cnt0_s, sat_s, out);
    end
    sel = 1'b1;
    #1;
    n_cmp++;
    if (out !== 2'b01) begin
      n_err++;
      $display("FAIL async_reset_track: out=%b required 01", out);
    end
    $display("async_reset out_q=%b cnt0=%0d out=%b", out_q, cnt0, out);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'bx;
    clr = 1'bx;
    test_truth_table();
    test_reset();
    test_registered();
    test_counting();
    test_clr();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to2.md
# demux_1to2

1-to-2 demultiplexer with a purely combinational routing path, plus a registered copy of the outputs and optional per-channel activity counters. Routes the 1-bit `in` onto one of two output lanes selected by `sel`; the unselected lane is driven 0. Used as a leaf routing primitive. The clocked side-band exists for monitoring and timing-closure use and never affects the combinational outputs.

## Interface
Parameters:
- `CNT_W`, default 16: width of each activity counter (legal range 2–32).

Ports. Positional declaration order is `in`, `sel`, `out`, `clk`, `rst`, `clr`, `out_q`, `cnt0`, `cnt1`, `sat`. The first three ports must stay in that order.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high; clears all state.
- `in`  input  1  data bit to route.
- `sel`  input  1  lane select; 0 selects `out[1]`, 1 selects `out[0]`.
- `out`  output  2  combinational routed data.
- `clr`  input  1  synchronous clear of counters and `sat`; active-high.
- `out_q`  output  2  registered copy of `out`.
- `cnt0`  output  CNT_W  count of cycles with `out[1]`=1 (sel=0 deliveries).
- `cnt1`  output  CNT_W  count of cycles with `out[0]`=1 (sel=1 deliveries).
- `sat`  output  1  sticky flag: either counter has reached all-ones.

## Operation
- Routing function:
  - `out[1] = in & ~sel`
  - `out[0] = in & sel`
- Truth table, listed as in/sel → out:
  - 0/0 → 00
  - 1/0 → 10
  - 0/1 → 00
  - 1/1 → 01
- At most one bit of `out` is ever 1. When `in`=0, `out`=00 regardless of `sel`.
- `out` depends only on `in` and `sel`. It must be correct with `clk`, `rst` and `clr` unconnected or undriven.
- `out_q` loads `out` every rising `clk` edge.
- Counter behaviour (stats feature):
  - On each rising edge, `cnt0` increments if `out[1]`=1.
  - On each rising edge, `cnt1` increments if `out[0]`=1.
  - Both counters saturate at 2^CNT_W−1; there is no wrap-around.
- `sat` sets on the edge where either counter becomes all-ones. It stays set until `rst` or `clr`.
- `clr` has priority over increment. On an edge with `clr`=1, both counters and `sat` become 0, whatever the routing.
- `clr` does not affect `out_q`.

## Timing
- `out`: zero-cycle combinational path from `in`/`sel`. There is no latch and no clock dependency.
- `out_q`: 1-cycle latency from `out`.
- Counters and `sat`: the effect is visible 1 cycle after the qualifying cycle.
- Reset values while `rst`=1, asserted asynchronously: `out_q`=00, `cnt0`=0, `cnt1`=0, `sat`=0.
- Reset does not force `out`; `out` keeps following `in`/`sel` during reset.
- Reset deassertion: the first update occurs on the next rising `clk`.
- Reset asserted mid-count clears immediately, without waiting for `clk`.
- Same-edge events:
  - `clr` together with a saturating increment → result is 0 and `sat`=0.
  - A counter at saturation with a qualifying cycle → holds its value.

## Configuration
- Macro `DEMUX1TO2_STATS_EN`.
- Defined: `cnt0`, `cnt1` and `sat` are implemented as above.
- Not defined:
  - The counter logic is not compiled.
  - `cnt0` and `cnt1` are tied to 0 and `sat` is tied to 0.
  - Ports remain present, so the port list is unchanged.
  - `clr` is ignored.
- `out` and `out_q` behave identically in both builds.

## Test plan
- Combinational truth table, `clk`/`rst` unconnected. Drive in/sel = 0/0, 1/0, 0/1, 1/1, holding each 10 time units. Required `out` = 00, 10, 00, 01 respectively, with no X values.
- Registered path: `rst` pulse, then in=1, sel=1 for one cycle. Required: `out_q`=00 during reset and `out_q`=01 one cycle after.
- Counting:
  - Stimulus: in=1, sel=0 for 5 cycles, then sel=1 for 3 cycles, then in=0 for 4 cycles.
  - Required with `DEMUX1TO2_STATS_EN`: `cnt0`=5, `cnt1`=3, `sat`=0.
  - Required without the macro: all three outputs read 0.
- Saturation:
  - Stimulus: `CNT_W`=2, in=1, sel=1 for 6 cycles.
  - Required: `cnt1` sticks at 3.
  - Required: `sat`=1 from the edge where `cnt1` reaches 3.
  - Required: `cnt0`=0 throughout.
- `clr` priority: with counters nonzero, assert `clr` while in=1. Required: counters and `sat` read 0 the next cycle, and `out_q` is unaffected.
- Asynchronous reset mid-run: assert `rst` between clock edges. Required: `out_q`, counters and `sat` clear before the next edge, while `out` keeps tracking `in`/`sel`.
